// File: rtl/uart_crc_engine_pkg.sv
// uart_crc_pkg: FSM state type, default CRC-8 polynomial and shared one-bit CRC update.
//   crc_step(crc, b, pol): operands left-aligned in 32 bits so any CRC width 8..32 can use it.
package uart_crc_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [7:0] CRC8_POL_DEFAULT = 8'h07;
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b, input logic [31:0] pol);
    return {crc[30:0], 1'b0} ^ ((crc[31] ^ b) ? pol : 32'h0);
  endfunction
endpackage

// File: rtl/uart_crc_engine_if.sv
// uart_crc_engine_if: word handshake and CRC result bundle between a source and the CRC engine.
//   init_i, data_valid_i, data_i : source -> engine
//   data_ready_o, busy_o, crc_valid_o, crc_o, crc_ok_o : engine -> source
//   crc_ok_o exists only when UART_CRC_CHECK_EN is defined.
interface uart_crc_engine_if #(parameter int DATA_W = 8, parameter int CRC_W = 8);
  logic init_i, data_valid_i, data_ready_o, busy_o, crc_valid_o;
  logic [DATA_W-1:0] data_i;
  logic [CRC_W-1:0] crc_o;
`ifdef UART_CRC_CHECK_EN
  logic crc_ok_o;
  modport master(output init_i, data_valid_i, data_i, input data_ready_o, busy_o, crc_valid_o, crc_o, crc_ok_o);
  modport slave(input init_i, data_valid_i, data_i, output data_ready_o, busy_o, crc_valid_o, crc_o, crc_ok_o);
`else
  modport master(output init_i, data_valid_i, data_i, input data_ready_o, busy_o, crc_valid_o, crc_o);
  modport slave(input init_i, data_valid_i, data_i, output data_ready_o, busy_o, crc_valid_o, crc_o);
`endif
endinterface

// File: rtl/uart_crc_engine.sv
// uart_crc_engine: bit-serial CRC over DATA_W-bit words, one bit per clock, LSB- or MSB-first.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : uart_crc_engine_if.slave (init, valid/ready/data in; busy, crc_valid, crc, crc_ok out)
//   Optional UART_CRC_CHECK_EN adds CHECK_RES and the registered residue flag crc_ok_o.
module uart_crc_engine
  import uart_crc_pkg::*;
#(
  parameter int CRC_W = 8,
  parameter logic [CRC_W-1:0] CRC_POL = CRC_W'(CRC8_POL_DEFAULT),
  parameter logic [CRC_W-1:0] CRC_INIT = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int DATA_W = 8,
  parameter bit LSB_FIRST = 1'b1
`ifdef UART_CRC_CHECK_EN
  , parameter logic [CRC_W-1:0] CHECK_RES = '0
`endif
) (
  input logic clk_i,
  input logic rst_ni,
  uart_crc_engine_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam int SH = 32 - CRC_W;
  state_t r_state, w_state_n;
  logic [CRC_W-1:0] r_crc, w_crc_n;
  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] w_step;
  logic w_bit, w_last, w_accept;
  assign w_bit = LSB_FIRST ? r_sh[0] : r_sh[DATA_W-1];
  // CRC is left-aligned so the shared step sees the register MSB at bit 31.
  assign w_step = crc_step(32'(r_crc) << SH, w_bit, 32'(CRC_POL) << SH);
  assign w_crc_n = CRC_W'(w_step >> SH);
  assign w_last = r_cnt == CNT_W'(DATA_W - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_state_n;
  always_comb begin
    bus.data_ready_o = r_state == IDLE && !bus.init_i;
    bus.crc_valid_o = r_state == DONE && !bus.init_i;
    bus.busy_o = r_state != IDLE;
    bus.crc_o = r_crc ^ XOR_OUT;
    w_accept = bus.data_valid_i && bus.data_ready_o;
    w_state_n = bus.init_i ? IDLE :
                r_state == IDLE ? (w_accept ? SHIFT : IDLE) :
                r_state == SHIFT ? (w_last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_crc <= CRC_INIT;
      r_sh <= '0;
      r_cnt <= '0;
    end else if (bus.init_i) r_crc <= CRC_INIT;
    else if (w_accept) begin
      r_sh <= bus.data_i;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_crc <= w_crc_n;
      r_sh <= LSB_FIRST ? r_sh >> 1 : r_sh << 1;
      r_cnt <= r_cnt + 1'b1;
    end
`ifdef UART_CRC_CHECK_EN
  logic r_ok;
  // Loaded on the last fold so the flag is valid alongside crc_valid_o and held afterwards.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_ok <= 1'b0;
    else if (bus.init_i) r_ok <= 1'b0;
    else if (r_state == SHIFT && w_last) r_ok <= w_crc_n == CHECK_RES;
  assign bus.crc_ok_o = r_ok;
`endif
endmodule

// File: tb/tb_uart_crc_engine.sv
// tb_uart_crc_engine: three engine builds (default, MSB-first, XOR_OUT=FF) on one stimulus stream.
module tb_uart_crc_engine;
  logic clk_i = 1'b0, rst_n = 1'b1, init = 1'b0, valid = 1'b0;
  logic [7:0] data = 8'h00;
  int n_asrt = 0, n_fail = 0;
  logic [7:0] e_d = 8'h00, e_m = 8'h00, e_x = 8'h00;
  logic [7:0] q_d[$], q_m[$], q_x[$];

  always #5 clk_i = ~clk_i;

  uart_crc_engine_if #(.DATA_W(8), .CRC_W(8)) if_d ();
  uart_crc_engine_if #(.DATA_W(8), .CRC_W(8)) if_m ();
  uart_crc_engine_if #(.DATA_W(8), .CRC_W(8)) if_x ();
  assign if_d.init_i = init;
  assign if_d.data_valid_i = valid;
  assign if_d.data_i = data;
  assign if_m.init_i = init;
  assign if_m.data_valid_i = valid;
  assign if_m.data_i = data;
  assign if_x.init_i = init;
  assign if_x.data_valid_i = valid;
  assign if_x.data_i = data;

  uart_crc_engine u_d (.clk_i(clk_i), .rst_ni(rst_n), .bus(if_d));
  uart_crc_engine #(.LSB_FIRST(1'b0)) u_m (.clk_i(clk_i), .rst_ni(rst_n), .bus(if_m));
  uart_crc_engine #(.XOR_OUT(8'hFF)) u_x (.clk_i(clk_i), .rst_ni(rst_n), .bus(if_x));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] c, input logic [7:0] w, input bit lsb);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b = lsb ? w[i] : w[7-i];
      c = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic clear_sb();
    e_d = 8'h00;
    e_m = 8'h00;
    e_x = 8'h00;
    q_d.delete();
    q_m.delete();
    q_x.delete();
  endtask

  always @(negedge clk_i)
    if (rst_n && if_d.crc_valid_o) begin
      if (q_d.size() != 0) chk("d_crc", 32'(if_d.crc_o), 32'(q_d.pop_front()));
      else chk("d_unexpected_valid", 32'(if_d.crc_valid_o), 0);
    end
  always @(negedge clk_i)
    if (rst_n && if_m.crc_valid_o) begin
      if (q_m.size() != 0) chk("m_crc", 32'(if_m.crc_o), 32'(q_m.pop_front()));
      else chk("m_unexpected_valid", 32'(if_m.crc_valid_o), 0);
    end
  always @(negedge clk_i)
    if (rst_n && if_x.crc_valid_o) begin
      if (q_x.size() != 0) chk("x_crc", 32'(if_x.crc_o), 32'(q_x.pop_front()));
      else chk("x_unexpected_valid", 32'(if_x.crc_valid_o), 0);
    end

  // Called at a negedge; returns at the negedge where the engine is ready again.
  task automatic send(input logic [7:0] w);
    int t = 0, lat = 0, lo = 0;
    while (!if_m.data_ready_o && t < 40) begin
      @(negedge clk_i);
      t++;
    end
    valid = 1'b1;
    data = w;
    e_d = model(e_d, w, 1'b1);
    q_d.push_back(e_d);
    e_m = model(e_m, w, 1'b0);
    q_m.push_back(e_m);
    e_x = model(e_x, w, 1'b1);
    q_x.push_back(e_x ^ 8'hFF);
    @(negedge clk_i);
    valid = 1'b0;
    t = 1;
    while (!if_m.data_ready_o && t < 20) begin
      if (if_m.crc_valid_o) lat = t;
      lo++;
      @(negedge clk_i);
      t++;
    end
    chk("valid_latency", lat, 9);
    chk("ready_low_cycles", lo, 9);
  endtask

  task automatic do_init();
    init = 1'b1;
    clear_sb();
    @(negedge clk_i);
    init = 1'b0;
  endtask

  initial begin
    int nv;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_d_crc", 32'(if_d.crc_o), 32'h00);
    chk("rst_x_crc", 32'(if_x.crc_o), 32'hFF);
    chk("rst_busy", 32'(if_m.busy_o), 0);
    chk("rst_valid", 32'(if_m.crc_valid_o), 0);
`ifdef UART_CRC_CHECK_EN
    chk("rst_ok", 32'(if_m.crc_ok_o), 0);
`endif
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 32'(if_m.data_ready_o), 1);
    @(negedge clk_i);
    send(8'h00);
    chk("t1_d_crc", 32'(if_d.crc_o), 32'h00);
    do_init();
    for (int i = 0; i < 9; i++) send(8'(8'h31 + i));
    chk("t2_check_F4", 32'(if_m.crc_o), 32'hF4);
    do_init();
    send(8'h80);
    chk("t3_lsb_80", 32'(if_d.crc_o), 32'h07);
    chk("t3_xor_out", 32'(if_x.crc_o), 32'hF8);
`ifdef UART_CRC_CHECK_EN
    do_init();
    send(8'h01);
    send(8'h07);
    @(negedge clk_i);
    chk("t4_ok_good", 32'(if_m.crc_ok_o), 1);
    do_init();
    chk("t4_ok_cleared", 32'(if_m.crc_ok_o), 0);
    send(8'h01);
    send(8'h06);
    @(negedge clk_i);
    chk("t4_ok_bad", 32'(if_m.crc_ok_o), 0);
`endif
    do_init();
    send(8'h3C);
    valid = 1'b1;
    data = 8'hA5;
    @(negedge clk_i);
    valid = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("t5_busy_mid", 32'(if_m.busy_o), 1);
    init = 1'b1;
    clear_sb();
    @(negedge clk_i);
    init = 1'b0;
    chk("t5_abort_idle", 32'(if_m.busy_o), 0);
    chk("t5_abort_d_crc", 32'(if_d.crc_o), 32'h00);
    chk("t5_abort_x_crc", 32'(if_x.crc_o), 32'hFF);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      if (if_m.crc_valid_o) nv++;
      @(negedge clk_i);
    end
    chk("t5_no_valid", nv, 0);
    init = 1'b1;
    valid = 1'b1;
    data = 8'h5A;
    #1 chk("t5_ready_vs_init", 32'(if_m.data_ready_o), 0);
    @(negedge clk_i);
    init = 1'b0;
    valid = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("t5_not_taken", 32'(if_m.busy_o), 0);
    send(8'h01);
    chk("t5_resume", 32'(if_m.crc_o), 32'h07);
    valid = 1'b1;
    data = 8'h55;
    @(negedge clk_i);
    valid = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_n = 1'b0;
    clear_sb();
    #1;
    chk("t6_busy", 32'(if_m.busy_o), 0);
    chk("t6_valid", 32'(if_m.crc_valid_o), 0);
    chk("t6_m_crc", 32'(if_m.crc_o), 32'h00);
    chk("t6_x_crc", 32'(if_x.crc_o), 32'hFF);
    @(negedge clk_i);
    rst_n = 1'b1;
    send(8'h01);
    chk("t6_after_rst", 32'(if_m.crc_o), 32'h07);
    repeat (3) @(negedge clk_i);
    chk("sb_drained", q_d.size() + q_m.size() + q_x.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
